// File: rtl/pair_triple_bist.sv
// pair_triple_bist: sweeps all eight 3-bit patterns into a 2-of-3 detector and checks det_out against majority.
// Latency: pattern 000 visible the cycle after start; each pattern held SETTLE_CYCLES; done/results load on the 111 sample edge.
// Backpressure: none; start is ignored during RUN. Optional loop mode via PAIR_TRIPLE_BIST_LOOP_EN (chains sweeps while start high).
module pair_triple_bist #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       in0,
    output logic       in1,
    output logic       in2,
    input  logic       det_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_count,
    output logic [2:0] fail_pattern
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic       busy_nxt;
    logic       done_nxt;
    logic [2:0] pattern;
    logic [3:0] settle_cnt;
    logic [3:0] work_cnt;
    logic       first_seen;
    logic [2:0] first_pat;
    logic       expected;
    logic       sample;
    logic       sweep_end;
    logic       mismatch;
    logic       launch;

    // Golden 2-of-3 function of the pattern currently on the detector pins.
    assign expected  = (pattern[2] & pattern[1]) | (pattern[2] & pattern[0]) | (pattern[1] & pattern[0]);
    assign sample    = (state == RUN) && (settle_cnt == SETTLE_LAST);
    assign sweep_end = sample && (pattern == 3'd7);
    assign mismatch  = sample && (det_out != expected);
    assign launch    = (state != RUN) && start;

    // The pattern register is 0 outside RUN (it wraps 7->0 at sweep end), so the pins come straight from flops.
    assign in0 = pattern[2];
    assign in1 = pattern[1];
    assign in2 = pattern[0];

    // Next-state and next-value of the registered status outputs.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                if (sweep_end) begin
`ifdef PAIR_TRIPLE_BIST_LOOP_EN
                    state_nxt = start ? RUN : DONE;
`else
                    state_nxt = DONE;
`endif
                end
            end
            DONE: if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt == RUN);
        // done is a pulse when a loop continues, and a held level while parked in DONE.
        done_nxt = sweep_end || ((state == DONE) && !start);
    end

    // State register plus busy/done flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Pattern/settle sequencing and working mismatch accumulation for the current sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern    <= 3'd0;
            settle_cnt <= 4'd0;
            work_cnt   <= 4'd0;
            first_seen <= 1'b0;
            first_pat  <= 3'd0;
        end else if (launch) begin
            pattern    <= 3'd0;
            settle_cnt <= 4'd0;
            work_cnt   <= 4'd0;
            first_seen <= 1'b0;
            first_pat  <= 3'd0;
        end else if (state == RUN) begin
            if (sample) begin
                settle_cnt <= 4'd0;
                pattern    <= pattern + 3'd1;
                if (sweep_end) begin
                    // Clear the working set so a looped sweep starts fresh.
                    work_cnt   <= 4'd0;
                    first_seen <= 1'b0;
                    first_pat  <= 3'd0;
                end else if (mismatch) begin
                    work_cnt <= work_cnt + 4'd1;
                    if (!first_seen) begin
                        first_seen <= 1'b1;
                        first_pat  <= pattern;
                    end
                end
            end else begin
                settle_cnt <= settle_cnt + 4'd1;
            end
        end
    end

    // Result registers, loaded at sweep end including the final pattern-7 sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            pass         <= 1'b0;
            fail_count   <= 4'd0;
            fail_pattern <= 3'd0;
        end else if (sweep_end) begin
            fail_count   <= work_cnt + {3'b000, mismatch};
            fail_pattern <= first_seen ? first_pat : (mismatch ? pattern : 3'b000);
            pass         <= (work_cnt == 4'd0) && !mismatch;
        end
    end

endmodule

// File: tb/tb_pair_triple_bist.sv
// Bench for pair_triple_bist: two instances (settle 1 with combinational detector, settle 3 with 2-cycle detector).
// A sweep-level reference model is compared every cycle; directed cases pin literal results.
// Detector faults are injected as a per-pattern flip mask applied to the true majority.
module tb_pair_triple_bist;

`ifdef PAIR_TRIPLE_BIST_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [1:0] st;
    logic [7:0] mask [2];
    logic [1:0] i0, i1, i2, det, busy_w, done_w, pass_w;
    logic [1:0][3:0] fc_w;
    logic [1:0][2:0] fp_w;
    logic [2:0] pat0, pat1;
    logic [2:0] q1 = 3'd0;
    logic [2:0] q2 = 3'd0;

    int  n_pass = 0;
    int  n_tot  = 0;
    bit  armed  = 1'b0;

    // Reference model state, per instance
    bit  m_run  [2];
    bit  m_done [2];
    bit  m_pass [2];
    int  m_t    [2];
    int  m_fc   [2];
    int  m_fp   [2];
    int  acc    [2];
    int  first  [2];

    always #5 clk = ~clk;

    function automatic logic maj3(input logic [2:0] p);
        return $countones(p) >= 2;
    endfunction

    function automatic int sc(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    pair_triple_bist #(.SETTLE_CYCLES(1)) dut0 (
        .clk(clk), .reset(rst), .start(st[0]),
        .in0(i0[0]), .in1(i1[0]), .in2(i2[0]), .det_out(det[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .fail_count(fc_w[0]), .fail_pattern(fp_w[0])
    );

    pair_triple_bist #(.SETTLE_CYCLES(3)) dut1 (
        .clk(clk), .reset(rst), .start(st[1]),
        .in0(i0[1]), .in1(i1[1]), .in2(i2[1]), .det_out(det[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .fail_count(fc_w[1]), .fail_pattern(fp_w[1])
    );

    // Detectors: instance 0 combinational, instance 1 with two cycles of latency.
    assign pat0   = {i0[0], i1[0], i2[0]};
    assign pat1   = {i0[1], i1[1], i2[1]};
    assign det[0] = maj3(pat0) ^ mask[0][pat0];
    assign det[1] = maj3(q2) ^ mask[1][q2];
    always @(posedge clk) begin
        q1 <= pat1;
        q2 <= q1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Sweep-level model: time index within a sweep, pattern = t / settle, sample on the last cycle of each window.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int s;
            int p;
            s = sc(i);
            if (rst) begin
                m_run[i] = 0; m_done[i] = 0; m_pass[i] = 0;
                m_fc[i] = 0; m_fp[i] = 0; m_t[i] = 0; acc[i] = 0; first[i] = -1;
            end else if (m_run[i]) begin
                if (m_t[i] % s == s - 1) begin
                    p = m_t[i] / s;
                    if (det[i] != maj3(3'(p))) begin
                        acc[i]++;
                        if (first[i] < 0) first[i] = p;
                    end
                end
                if (m_t[i] == 8 * s - 1) begin
                    m_fc[i]   = acc[i];
                    m_fp[i]   = (first[i] < 0) ? 0 : first[i];
                    m_pass[i] = (acc[i] == 0);
                    m_done[i] = 1;
                    m_run[i]  = LOOP && st[i];
                    m_t[i] = 0; acc[i] = 0; first[i] = -1;
                end else begin
                    m_t[i]++;
                    m_done[i] = 0;
                end
            end else if (st[i]) begin
                m_run[i] = 1; m_done[i] = 0; m_t[i] = 0; acc[i] = 0; first[i] = -1;
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("busy%0d", i), busy_w[i], m_run[i]);
                chk($sformatf("done%0d", i), done_w[i], m_done[i]);
                chk($sformatf("pass%0d", i), pass_w[i], m_pass[i]);
                chk($sformatf("fail_count%0d", i), fc_w[i], m_fc[i]);
                chk($sformatf("fail_pattern%0d", i), fp_w[i], m_fp[i]);
                chk($sformatf("pins%0d", i), {i0[i], i1[i], i2[i]}, m_run[i] ? (m_t[i] / sc(i)) : 0);
            end
        end
    end

    task automatic do_sweep(input int i, input logic [7:0] mk, input bit mid, output int blen);
        int n;
        mask[i] = mk;
        @(negedge clk); st[i] = 1'b1;
        @(negedge clk); st[i] = 1'b0;
        n = 0; blen = 0;
        while (!done_w[i] && n < 200) begin
            if (busy_w[i]) blen++;
            n++;
            st[i] = (mid && n == 5);
            @(negedge clk);
        end
        st[i] = 1'b0;
        chk($sformatf("sweep_done_seen%0d", i), done_w[i], 1);
    endtask

    task automatic lit(input string nm, input int i, input int blen, input int elen,
                       input int ep, input int efc, input int efp);
        chk({nm, "_busy_len"}, blen, elen);
        chk({nm, "_pass"}, pass_w[i], ep);
        chk({nm, "_fail_count"}, fc_w[i], efc);
        chk({nm, "_fail_pattern"}, fp_w[i], efp);
    endtask

    initial begin
        int blen;
        int n;
        int dn;
        st = 2'b00; mask[0] = 8'h00; mask[1] = 8'h00; rst = 1'b1;
        @(negedge clk); @(negedge clk);
        armed = 1'b1;
        rst = 1'b0;
        chk("reset_busy", busy_w[0], 0);
        chk("reset_done", done_w[0], 0);
        chk("reset_pins", pat0, 0);

        // Directed sweeps with literal expectations
        do_sweep(0, 8'h00, 1'b0, blen); lit("good", 0, blen, 8, 1, 0, 0);
        do_sweep(0, 8'hE8, 1'b0, blen); lit("stuck0", 0, blen, 8, 0, 4, 3);
        do_sweep(0, 8'h17, 1'b0, blen); lit("stuck1", 0, blen, 8, 0, 4, 0);
        do_sweep(0, 8'hFF, 1'b0, blen); lit("invert", 0, blen, 8, 0, 8, 0);
        do_sweep(1, 8'h00, 1'b1, blen); lit("lat2", 1, blen, 24, 1, 0, 0);

        // Reset on the 4th RUN cycle
        mask[0] = 8'h00;
        @(negedge clk); st[0] = 1'b1;
        @(negedge clk); st[0] = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy_w[0], 0);
        chk("rst_done", done_w[0], 0);
        chk("rst_fail_count", fc_w[0], 0);
        chk("rst_pins", pat0, 0);
        rst = 1'b0;
        do_sweep(0, 8'h00, 1'b0, blen); lit("after_rst", 0, blen, 8, 1, 0, 0);

        // Start held across a sweep end
        mask[0] = 8'h24;
        @(negedge clk); st[0] = 1'b1;
        n = 0;
        while (!busy_w[0] && n < 20) begin @(negedge clk); n++; end
        blen = 0; dn = 0;
        while (busy_w[0] && blen < 100) begin
            blen++;
            if (done_w[0]) dn++;
            if (blen == 10) st[0] = 1'b0;
            @(negedge clk);
        end
        st[0] = 1'b0;
        chk("held_busy_len", blen, LOOP ? 16 : 8);
        chk("held_done_in_run", dn, LOOP ? 1 : 0);
        n = 0;
        while (!(done_w[0] && !busy_w[0]) && n < 100) begin @(negedge clk); n++; end
        chk("held_done_seen", done_w[0], 1);
        chk("held_fail_count", fc_w[0], 2);
        chk("held_fail_pattern", fp_w[0], 2);

        // Random phase: random starts, fault masks and occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                st[i] = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 29) == 0) mask[i] = 8'($urandom);
            end
            rst = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk); st = 2'b00; rst = 1'b0;
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
